// File: rtl/adc_spi_sampler.sv
// Periodic SPI ADC sampler: frames a 16-clock read, keeps the low 12 bits and
// averages 2^AVG_LOG2 conversions before presenting them on adc_data.
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] adc_data,
    output logic        adc_data_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned DivW  = $clog2(CLK_DIV);
    localparam int unsigned TickW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned AccW  = 12 + AVG_LOG2;
    localparam int unsigned CntW  = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StUpdate
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [4:0]        half_q, half_d;
    logic [11:0]       shift_q, shift_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [11:0]       data_q, data_d;

    logic              tick;
    logic              div_last;
    logic              cnt_last;
    logic [AccW-1:0]   acc_sum;
    logic [11:0]       avg;

    assign tick     = enable && (tick_cnt_q == TickW'(SAMPLE_PERIOD - 1));
    assign div_last = (div_q == DivW'(CLK_DIV - 1));
    assign cnt_last = (cnt_q == CntW'((1 << AVG_LOG2) - 1));
    assign acc_sum  = acc_q + AccW'(shift_q);
    assign avg      = 12'(acc_sum >> AVG_LOG2);

    always_comb begin
        tick_cnt_d = tick_cnt_q + TickW'(1);
        if (!enable || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_last ? '0 : div_q + DivW'(1);
        half_d  = half_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                div_d  = '0;
                half_d = '0;
                if (tick) begin
                    state_d = StCsSetup;
                end else if (!enable) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            StCsSetup: begin
                if (div_last) state_d = StShift;
            end
            StShift: begin
                if (div_last) begin
                    half_d = half_q + 5'd1;
                    // Capture on the edge that raises SCLK; older bits fall off the top.
                    if (!half_q[0]) shift_d = {shift_q[10:0], adc_miso};
                    if (half_q == 5'd31) state_d = StCsHold;
                end
            end
            StCsHold: begin
                if (div_last) state_d = StUpdate;
            end
            StUpdate: begin
                state_d = StIdle;
                if (cnt_last) begin
                    data_d = avg;
                    acc_d  = '0;
                    cnt_d  = '0;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            div_q      <= '0;
            half_q     <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            half_q     <= half_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
        end
    end

    // The new average is presented during the valid cycle itself, then held.
    assign adc_data_valid = (state_q == StUpdate) && cnt_last;
    assign adc_data       = adc_data_valid ? avg : data_q;
    assign adc_cs_n       = !((state_q == StCsSetup) || (state_q == StShift));
    assign adc_sclk       = (state_q == StShift) && half_q[0];
    assign busy           = (state_q != StIdle);
    assign overrun        = tick && busy;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench: three sampler instances (single, 4x and 16x averaging) driven
// by a behavioural SPI ADC model that serves a per-instance list of words.
module tb_adc_spi_sampler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  en = '0;
    logic [2:0]  miso = '0;
    logic [2:0]  cs_n, sclk, busy, valid, ovr;
    logic [11:0] data [3];

    logic [15:0] words [3][64];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Monitor / ADC model state (written only by the monitor process)
    int          rises [3] = '{0, 0, 0};
    int          tot_rises [3] = '{0, 0, 0};
    int          nfull [3] = '{0, 0, 0};
    int          nstart [3] = '{0, 0, 0};
    int          nvalid [3] = '{0, 0, 0};
    int          novr [3] = '{0, 0, 0};
    int          widx [3] = '{0, 0, 0};
    int          csfall [3] = '{0, 0, 0};
    int          vcyc [3] = '{0, 0, 0};
    int          ovfirst [3] = '{0, 0, 0};
    logic [11:0] vdata [3] = '{12'h0, 12'h0, 12'h0};
    logic [15:0] cur [3] = '{16'h0, 16'h0, 16'h0};
    logic        prev_cs [3] = '{1'b1, 1'b1, 1'b1};
    logic        prev_sclk [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(50), .AVG_LOG2(0)) u_avg0 (
        .clk(clk), .reset(reset), .enable(en[0]), .adc_miso(miso[0]),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_data(data[0]),
        .adc_data_valid(valid[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(2)) u_avg2 (
        .clk(clk), .reset(reset), .enable(en[1]), .adc_miso(miso[1]),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_data(data[1]),
        .adc_data_valid(valid[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(80), .AVG_LOG2(4)) u_avg4 (
        .clk(clk), .reset(reset), .enable(en[2]), .adc_miso(miso[2]),
        .adc_cs_n(cs_n[2]), .adc_sclk(sclk[2]), .adc_data(data[2]),
        .adc_data_valid(valid[2]), .busy(busy[2]), .overrun(ovr[2])
    );

    // cyc equals the number of rising edges seen, i.e. the current cycle index
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC model: next word on CS fall, next bit after each SCLK rise
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (prev_cs[i] && !cs_n[i]) begin
                nstart[i]++;
                csfall[i] = cyc;
                rises[i]  = 0;
                cur[i]    = words[i][widx[i]];
                widx[i]   = (widx[i] + 1) % 64;
                miso[i]   = cur[i][15];
            end
            if (!prev_sclk[i] && sclk[i]) begin
                rises[i]++;
                tot_rises[i]++;
                miso[i] = (rises[i] < 16) ? cur[i][15 - rises[i]] : 1'b0;
            end
            if (!prev_cs[i] && cs_n[i] && rises[i] == 16) nfull[i]++;
            if (valid[i]) begin
                vdata[i] = data[i];
                vcyc[i]  = cyc;
                nvalid[i]++;
            end
            if (ovr[i]) begin
                if (novr[i] == 0) ovfirst[i] = cyc;
                novr[i]++;
            end
            prev_cs[i]   = cs_n[i];
            prev_sclk[i] = sclk[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    int k, k3, k5, base_full, base_valid, tr;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 32'h7);
        check("rst_sclk", 32'(sclk), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_data", 32'(data[1]), 32'h0);
        reset = 1'b1;
        wait_to(cyc + 2);

        // Single-conversion output, exact latency and overruns (SAMPLE_PERIOD < frame)
        words[0][0] = 16'h0A5C;
        words[0][1] = 16'hF123;
        words[0][2] = 16'h5FFF;
        k = cyc;
        en[0] = 1'b1;
        wait_to(k + 52);
        check("a_cs_fall", 32'(csfall[0]), 32'(k + 50));
        check("a_busy", 32'(busy[0]), 32'h1);
        wait_to(k + 101);
        check("a_ovr_first", 32'(ovfirst[0]), 32'(k + 99));
        check("a_ovr_keep_frame", 32'(nstart[0]), 32'h1);
        wait_to(k + 120);
        check("a_valid_cyc", 32'(vcyc[0]), 32'(k + 118));
        check("a_data0", 32'(vdata[0]), 32'hA5C);
        check("a_rises16", 32'(nfull[0]), 32'h1);
        wait_to(k + 220);
        check("a_data1", 32'(vdata[0]), 32'h123);
        check("a_valid1_cyc", 32'(vcyc[0]), 32'(k + 218));
        wait_to(k + 330);
        en[0] = 1'b0;
        check("a_data2", 32'(vdata[0]), 32'hFFF);
        check("a_nvalid", 32'(nvalid[0]), 32'h3);
        check("a_novr", 32'(novr[0]), 32'h3);
        check("a_nfull", 32'(nfull[0]), 32'h3);
        check("a_busy_end", 32'(busy[0]), 32'h0);

        // 16-way average of full-scale conversions (junk in discarded bits)
        for (int j = 0; j < 16; j++) words[2][j] = 16'hAFFF;
        wait_to(cyc + 2);
        k = cyc;
        en[2] = 1'b1;
        wait_to(k + 1340);
        check("c_no_early_valid", 32'(nvalid[2]), 32'h0);
        wait_to(k + 1350);
        en[2] = 1'b0;
        check("c_nvalid", 32'(nvalid[2]), 32'h1);
        check("c_data", 32'(vdata[2]), 32'hFFF);
        check("c_valid_cyc", 32'(vcyc[2]), 32'(k + 1348));
        check("c_novr", 32'(novr[2]), 32'h0);
        check("c_nfull", 32'(nfull[2]), 32'd16);

        // 4-way average: 100,101,102,104 -> 407>>2 = 101
        words[1][0] = 16'h3064;
        words[1][1] = 16'h7065;
        words[1][2] = 16'h0066;
        words[1][3] = 16'hF068;
        wait_to(cyc + 2);
        k = cyc;
        en[1] = 1'b1;
        wait_to(k + 460);
        check("b_no_early_valid", 32'(nvalid[1]), 32'h0);
        wait_to(k + 470);
        en[1] = 1'b0;
        check("b_nvalid", 32'(nvalid[1]), 32'h1);
        check("b_data", 32'(vdata[1]), 32'd101);
        check("b_valid_cyc", 32'(vcyc[1]), 32'(k + 468));

        // Enable dropped during the 2nd frame's shift; partial group must be discarded
        words[1][4] = 16'h01F4;
        words[1][5] = 16'h0258;
        words[1][6] = 16'h000A;
        words[1][7] = 16'h0014;
        words[1][8] = 16'h001E;
        words[1][9] = 16'h0029;
        wait_to(cyc + 5);
        base_full = nfull[1];
        k = cyc;
        en[1] = 1'b1;
        wait_to(k + 220);
        check("d_busy_mid", 32'(busy[1]), 32'h1);
        en[1] = 1'b0;
        wait_to(k + 280);
        check("d_busy_done", 32'(busy[1]), 32'h0);
        check("d_frames_done", 32'(nfull[1] - base_full), 32'h2);
        check("d_no_valid", 32'(nvalid[1]), 32'h1);
        wait_to(k + 290);
        k3 = cyc;
        en[1] = 1'b1;
        wait_to(k3 + 470);
        en[1] = 1'b0;
        check("d_nvalid", 32'(nvalid[1]), 32'h2);
        check("d_data", 32'(vdata[1]), 32'd25);
        check("d_valid_cyc", 32'(vcyc[1]), 32'(k3 + 468));

        // Reset in the middle of a frame, with a partial group accumulated
        words[1][10] = 16'h00C8;
        words[1][11] = 16'h00C8;
        words[1][12] = 16'h00C8;
        words[1][13] = 16'h03E8;
        words[1][14] = 16'h03E8;
        words[1][15] = 16'h03E8;
        words[1][16] = 16'h03EC;
        wait_to(cyc + 5);
        k = cyc;
        en[1] = 1'b1;
        wait_to(k + 320);
        check("e_busy_pre", 32'(busy[1]), 32'h1);
        reset = 1'b0;
        #1;
        check("e_cs_n", 32'(cs_n[1]), 32'h1);
        check("e_sclk", 32'(sclk[1]), 32'h0);
        check("e_busy", 32'(busy[1]), 32'h0);
        check("e_valid", 32'(valid[1]), 32'h0);
        check("e_ovr", 32'(ovr[1]), 32'h0);
        check("e_data", 32'(data[1]), 32'h0);
        check("e_data_other", 32'(data[0]), 32'h0);
        tr = tot_rises[1];
        base_valid = nvalid[1];
        wait_to(k + 325);
        k5 = cyc;
        reset = 1'b1;
        wait_to(k5 + 102);
        check("e_tick_after_rel", 32'(csfall[1]), 32'(k5 + 100));
        check("e_no_sclk", 32'(tot_rises[1]), 32'(tr));
        wait_to(k5 + 460);
        check("e_no_early_valid", 32'(nvalid[1]), 32'(base_valid));
        wait_to(k5 + 470);
        en[1] = 1'b0;
        check("e_nvalid", 32'(nvalid[1]), 32'(base_valid + 1));
        check("e_data_avg", 32'(vdata[1]), 32'd1001);
        check("e_valid_cyc", 32'(vcyc[1]), 32'(k5 + 468));
        check("e_novr", 32'(novr[1]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (>=2).
REQ-002 The block SHALL have parameter SAMPLE_PERIOD, default 1000, meaning clk cycles between conversion starts (>=2).
REQ-003 The block SHALL have parameter AVG_LOG2, default 2, meaning log2 of conversions averaged per output (0..4).
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port enable  input  1  enables periodic conversions.
REQ-007 The block SHALL have port adc_miso  input  1  serial data from external ADC.
REQ-008 The block SHALL have port adc_cs_n  output  1  ADC chip select, active-low.
REQ-009 The block SHALL have port adc_sclk  output  1  ADC serial clock, idle low.
REQ-010 The block SHALL have port adc_data  output  12  averaged sample, held between updates.
REQ-011 The block SHALL have port adc_data_valid  output  1  one-cycle pulse when adc_data updates.
REQ-012 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 The block SHALL have port overrun  output  1  one-cycle pulse when a sample tick is dropped.

Function
REQ-014 Tick counter SHALL count 0..SAMPLE_PERIOD-1 while enable=1, generate tick when at SAMPLE_PERIOD-1 and wrap to 0; held at 0 while enable=0.
REQ-015 FSM states SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE.
REQ-016 IDLE->CS_SETUP on tick; tick in cycle T SHALL drive adc_cs_n=0 and busy=1 from cycle T+1.
REQ-017 CS_SETUP SHALL last CLK_DIV cycles with adc_sclk=0, then enter SHIFT.
REQ-018 SHIFT SHALL produce 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high (32*CLK_DIV cycles total).
REQ-019 adc_miso SHALL be captured on the clk edge where adc_sclk rises; bits 1-4 discarded, bits 5-16 form 12-bit value MSB first.
REQ-020 CS_HOLD SHALL drive adc_sclk=0, adc_cs_n=1 for CLK_DIV cycles; adc_cs_n rises in cycle T+1+33*CLK_DIV.
REQ-021 UPDATE (1 cycle, cycle T+1+34*CLK_DIV) SHALL add the value to a (12+AVG_LOG2)-bit accumulator and increment a conversion count, then return to IDLE.
REQ-022 When count reaches 2^AVG_LOG2, adc_data SHALL load (accumulator+value)>>AVG_LOG2 (truncating), adc_data_valid SHALL pulse in the same cycle, and accumulator and count SHALL clear.
REQ-023 AVG_LOG2=0 SHALL output every conversion unmodified.
REQ-024 Accumulator SHALL never overflow: 2^AVG_LOG2 conversions of 0xFFF yield 0xFFF.
REQ-025 A tick arriving while busy=1 SHALL be dropped, pulse overrun for that cycle, and not abort or restart the current frame.
REQ-026 enable falling mid-frame SHALL let the frame complete and be accumulated; once IDLE with enable=0, accumulator and count SHALL clear, adc_data retained.
REQ-027 busy SHALL be 1 from CS_SETUP entry through the UPDATE cycle inclusive.

Reset
REQ-028 reset=0 SHALL immediately force adc_cs_n=1, adc_sclk=0, adc_data=0, adc_data_valid=0, busy=0, overrun=0, FSM=IDLE, counters and accumulator=0, including mid-frame.
REQ-029 After reset release, no adc_data_valid SHALL occur until a full new averaging group completes.

Verification
REQ-030 Assert reset mid-run -> all outputs at REQ-028 values in same cycle; no SCLK toggles until next tick after release.
REQ-031 AVG_LOG2=0, CLK_DIV=2, model returns 0000_1010_0101_1100 -> adc_data=0xA5C, valid pulse exactly at T+69, 16 SCLK rising edges observed.
REQ-032 AVG_LOG2=2, conversions 100,101,102,104 -> single valid pulse after 4th frame, adc_data=101 (407>>2).
REQ-033 AVG_LOG2=4, sixteen conversions of 0xFFF -> adc_data=0xFFF.
REQ-034 SAMPLE_PERIOD=50, CLK_DIV=2 (frame 70 cycles) -> overrun pulses on ticks landing in frames, every started frame completes with full 16 SCLKs.
REQ-035 enable dropped during SHIFT of 2nd of 4 frames -> frame completes, no valid pulse, re-enable then 4 fresh frames produce correct average.
